// File: rtl/nr_pipe.sv
// Pipelined multi-channel NOR/OR cell: per-lane reduction, DEPTH registered stages with valid tag.
// Optional NR_PIPE_FILTER_EN adds a per-lane 3-sample glitch filter on Z without extra latency.
module nr_pipe #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 1,
    parameter int INVERT   = 0
) (
    input  logic                      CK,
    input  logic                      RSTN,
    input  logic                      CE,
    input  logic                      VI,
    input  logic [WIDTH*CHANNELS-1:0] A,
    output logic [CHANNELS-1:0]       Z,
    output logic                      VO
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("nr_pipe: DEPTH must be at least 1");
    end

    logic [CHANNELS-1:0]            w_f;
    logic [DEPTH-1:0][CHANNELS-1:0] r_data;
    logic [DEPTH-1:0]               r_valid;
    logic [CHANNELS-1:0]            w_last_d;
    logic                           w_last_v;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        if (INVERT != 0) begin : g_or
            assign w_f[c] = |A[c*WIDTH +: WIDTH];
        end else begin : g_nor
            assign w_f[c] = ~|A[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            r_data  <= '0;
            r_valid <= '0;
        end else if (CE) begin
            r_data[0]  <= w_f;
            r_valid[0] <= VI;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Value about to be captured into the last stage; the filter works on this so it adds no cycle.
    if (DEPTH == 1) begin : g_last_in_port
        assign w_last_d = w_f;
        assign w_last_v = VI;
    end else begin : g_last_in_stage
        assign w_last_d = r_data[DEPTH-2];
        assign w_last_v = r_valid[DEPTH-2];
    end

    assign VO = r_valid[DEPTH-1];

`ifdef NR_PIPE_FILTER_EN
    logic [CHANNELS-1:0]      r_z;
    logic [CHANNELS-1:0][1:0] r_cnt;

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            r_z   <= '0;
            r_cnt <= '0;
        end else if (CE) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!w_last_v || (w_last_d[c] == r_z[c])) begin
                    r_cnt[c] <= 2'd0;
                end else if (r_cnt[c] == 2'd2) begin
                    r_z[c]   <= w_last_d[c];
                    r_cnt[c] <= 2'd0;
                end else begin
                    r_cnt[c] <= r_cnt[c] + 2'd1;
                end
            end
        end
    end

    assign Z = r_z;
`else
    assign Z = r_data[DEPTH-1];
`endif

endmodule

// File: tb/tb_nr_pipe.sv
// Self-checking bench for nr_pipe: five configurations share stimulus and are compared against
// a sample-history reference model (plus filter model when NR_PIPE_FILTER_EN is defined).
module tb_nr_pipe;

    logic        clk = 1'b0;
    logic        rstn, ce, vi;
    logic [14:0] a;
    logic [1:0]  z0, z1, z2, z3;
    logic [2:0]  z4;
    logic        vo0, vo1, vo2, vo3, vo4;
    logic [2:0]  z_act [5];
    logic        vo_act [5];

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        logic        v;
        logic [14:0] a;
    } samp_t;

    samp_t      hist [$];
    logic [2:0] fz [5];
    int         fc [5][3];

    always #5 clk = ~clk;

    nr_pipe #(.WIDTH(2), .CHANNELS(2), .DEPTH(1), .INVERT(0)) u0 (
        .CK(clk), .RSTN(rstn), .CE(ce), .VI(vi), .A(a[3:0]), .Z(z0), .VO(vo0));
    nr_pipe #(.WIDTH(2), .CHANNELS(2), .DEPTH(1), .INVERT(1)) u1 (
        .CK(clk), .RSTN(rstn), .CE(ce), .VI(vi), .A(a[3:0]), .Z(z1), .VO(vo1));
    nr_pipe #(.WIDTH(2), .CHANNELS(2), .DEPTH(4), .INVERT(0)) u2 (
        .CK(clk), .RSTN(rstn), .CE(ce), .VI(vi), .A(a[3:0]), .Z(z2), .VO(vo2));
    nr_pipe #(.WIDTH(2), .CHANNELS(2), .DEPTH(3), .INVERT(1)) u3 (
        .CK(clk), .RSTN(rstn), .CE(ce), .VI(vi), .A(a[3:0]), .Z(z3), .VO(vo3));
    nr_pipe #(.WIDTH(5), .CHANNELS(3), .DEPTH(2), .INVERT(0)) u4 (
        .CK(clk), .RSTN(rstn), .CE(ce), .VI(vi), .A(a), .Z(z4), .VO(vo4));

    assign z_act[0] = {1'b0, z0};
    assign z_act[1] = {1'b0, z1};
    assign z_act[2] = {1'b0, z2};
    assign z_act[3] = {1'b0, z3};
    assign z_act[4] = z4;
    assign vo_act[0] = vo0;
    assign vo_act[1] = vo1;
    assign vo_act[2] = vo2;
    assign vo_act[3] = vo3;
    assign vo_act[4] = vo4;

    function automatic int cfg_d(input int i);
        case (i)
            0, 1:    return 1;
            2:       return 4;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] lane_fn(input int i, input logic [14:0] av);
        int         w;
        int         ch;
        logic       any;
        logic [2:0] r;
        w  = (i == 4) ? 5 : 2;
        ch = (i == 4) ? 3 : 2;
        r  = '0;
        for (int c = 0; c < ch; c++) begin
            any = 1'b0;
            for (int b = 0; b < w; b++) any = any | av[c*w+b];
            r[c] = (i == 1 || i == 3) ? any : ~any;
        end
        return r;
    endfunction

    // Expected outputs: the sample accepted DEPTH accepted-edges ago, or zero if not yet that many.
    function automatic void exp_out(input int i, output logic [2:0] ez, output logic ev);
        int d;
        d  = cfg_d(i);
        ez = '0;
        ev = 1'b0;
        if (hist.size() >= d) begin
            ev = hist[hist.size()-d].v;
            ez = lane_fn(i, hist[hist.size()-d].a);
        end
`ifdef NR_PIPE_FILTER_EN
        ez = fz[i];
`endif
    endfunction

    task automatic step(input logic ce_i, input logic rstn_i, input logic vi_i,
                        input logic [14:0] a_i);
        logic [2:0] raw;
        logic       ev;
        int         d;
        ce   = ce_i;
        rstn = rstn_i;
        vi   = vi_i;
        a    = a_i;
        @(posedge clk);
        if (!rstn_i) begin
            hist.delete();
            for (int i = 0; i < 5; i++) begin
                fz[i] = '0;
                for (int c = 0; c < 3; c++) fc[i][c] = 0;
            end
        end else if (ce_i) begin
            hist.push_back('{v: vi_i, a: a_i});
            if (hist.size() > 8) void'(hist.pop_front());
            for (int i = 0; i < 5; i++) begin
                d   = cfg_d(i);
                ev  = (hist.size() >= d) ? hist[hist.size()-d].v : 1'b0;
                raw = (hist.size() >= d) ? lane_fn(i, hist[hist.size()-d].a) : 3'b000;
                for (int c = 0; c < 3; c++) begin
                    if (!ev || raw[c] == fz[i][c]) begin
                        fc[i][c] = 0;
                    end else begin
                        fc[i][c]++;
                        if (fc[i][c] == 3) begin
                            fz[i][c] = raw[c];
                            fc[i][c] = 0;
                        end
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int first [5];
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1, 15'h7fff);
            for (int i = 0; i < 5; i++) begin
                nvec++;
                if (z_act[i] !== 3'b000 || vo_act[i] !== 1'b0) begin
                    nfail++;
                    $display("FAIL reset_hold u%0d: got z=%b vo=%b, want z=000 vo=0",
                             i, z_act[i], vo_act[i]);
                end
            end
        end
        for (int i = 0; i < 5; i++) first[i] = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, (k == 1), 15'($urandom));
            for (int i = 0; i < 5; i++)
                if (vo_act[i] === 1'b1 && first[i] == 0) first[i] = k;
        end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (first[i] != cfg_d(i)) begin
                nfail++;
                $display("FAIL first_vo_latency u%0d: got edge %0d, want edge %0d",
                         i, first[i], cfg_d(i));
            end
        end
    endtask

    logic [3:0] fn_pat [3] = '{4'b0000, 4'b0100, 4'b1111};
    logic [1:0] fn_nor [3] = '{2'b11, 2'b01, 2'b00};
    logic [1:0] fn_or  [3] = '{2'b00, 2'b10, 2'b11};

    task automatic test_function();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1, {11'($urandom), fn_pat[k]});
            nvec++;
            if (z0 !== fn_nor[k] || z1 !== fn_or[k] || vo0 !== 1'b1) begin
                nfail++;
                $display("FAIL function A=%b: got nor=%b or=%b vo=%b, want nor=%b or=%b vo=1",
                         fn_pat[k], z0, z1, vo0, fn_nor[k], fn_or[k]);
            end
        end
    endtask

    task automatic test_stream();
        logic [2:0] ez;
        logic       ev;
        int         cnt, first;
        cnt   = 0;
        first = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b1, (k <= 8), {11'($urandom), 4'(k - 1)});
            if (vo2 === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
            end
            for (int i = 0; i < 5; i++) begin
                exp_out(i, ez, ev);
                nvec++;
                if (z_act[i] !== ez || vo_act[i] !== ev) begin
                    nfail++;
                    $display("FAIL stream u%0d edge %0d: got z=%b vo=%b, want z=%b vo=%b",
                             i, k, z_act[i], vo_act[i], ez, ev);
                end
            end
        end
        nvec++;
        if (cnt != 8 || first != 4) begin
            nfail++;
            $display("FAIL stream_run: got %0d VO cycles from edge %0d, want 8 from edge 4",
                     cnt, first);
        end
    endtask

    task automatic test_stall();
        logic [2:0] ez;
        logic       ev;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 16; k++) begin
            step(!(k >= 3 && k < 8), 1'b1, (k < 6) | 1'($urandom), 15'($urandom));
            for (int i = 0; i < 5; i++) begin
                exp_out(i, ez, ev);
                nvec++;
                if (z_act[i] !== ez || vo_act[i] !== ev) begin
                    nfail++;
                    $display("FAIL stall u%0d cycle %0d: got z=%b vo=%b, want z=%b vo=%b",
                             i, k, z_act[i], vo_act[i], ez, ev);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen, first;
        seen  = 0;
        first = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 15'($urandom));
        step(1'b1, 1'b0, 1'b1, 15'($urandom));
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 15'($urandom));
            if (vo2 === 1'b1) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nfail++;
            $display("FAIL reset_mid_flush: got %0d VO cycles, want 0", seen);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, (k == 1), 15'($urandom));
            if (vo2 === 1'b1 && first == 0) first = k;
        end
        nvec++;
        if (first != 4) begin
            nfail++;
            $display("FAIL reset_mid_latency: got edge %0d, want edge 4", first);
        end
    endtask

    task automatic test_random();
        logic [2:0] ez;
        logic       ev;
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 5) != 0, ($urandom % 60) != 0, 1'($urandom), 15'($urandom));
            for (int i = 0; i < 5; i++) begin
                exp_out(i, ez, ev);
                nvec++;
                if (z_act[i] !== ez || vo_act[i] !== ev) begin
                    nfail++;
                    $display("FAIL random u%0d cycle %0d: got z=%b vo=%b, want z=%b vo=%b",
                             i, k, z_act[i], vo_act[i], ez, ev);
                end
            end
        end
    endtask

`ifdef NR_PIPE_FILTER_EN
    logic [6:0] flt_raw = 7'b0111010;
    logic [6:0] flt_z   = 7'b1100000;

    task automatic test_filter();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 7; k++) begin
            // Lane 0 of u0 is a NOR: raw 1 needs A[1:0]=00, raw 0 needs A[1:0]=01.
            step(1'b1, 1'b1, 1'b1, {13'b0, 1'b0, ~flt_raw[k]});
            nvec++;
            if (z0[0] !== flt_z[k]) begin
                nfail++;
                $display("FAIL filter sample %0d: got z=%b, want z=%b", k, z0[0], flt_z[k]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 5; i++) begin
            fz[i] = '0;
            for (int c = 0; c < 3; c++) fc[i][c] = 0;
        end
        test_reset();
`ifndef NR_PIPE_FILTER_EN
        test_function();
`else
        test_filter();
`endif
        test_stream();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
